ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter that shares the single RAM/TIP/peribus port of the memory unit between the CPU datapath (requester 0) and a secondary master such as a DMA or debug loader (requester 1). It grants ownership with a registered request/grant handshake, muxes the owner's address, write data and write enable onto the memory port, and returns a read-valid strobe to the owner. Round-robin arbitration with a bounded burst length prevents either master from starving the other.

## Interface
- ADDR_W, 11, memory unit address width.
- DATA_W, 16, data word width.
- MAX_BURST, 8, maximum consecutive accesses before forced handover when the other side is requesting (≥1).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req / r1_req  in  1  requester wants the port; hold high until done.
- r0_we / r1_we  in  1  access is a write.
- r0_addr / r1_addr  in  ADDR_W  access address.
- r0_wdata / r1_wdata  in  DATA_W  write data.
- r0_gnt / r1_gnt  out  1  requester owns the port (registered).
- r0_rvalid / r1_rvalid  out  1  read data valid on rdata (registered).
- rdata  out  DATA_W  passthrough of mem_rdata.
- mem_addr  out  ADDR_W  to memory unit addr.
- mem_wdata  out  DATA_W  to memory unit in_data.
- mem_we  out  1  to memory unit write_enable.
- mem_rdata  in  DATA_W  from memory unit out_data.

## Operation
- States: IDLE, OWN0, OWN1. r0_gnt = (state==OWN0), r1_gnt = (state==OWN1).
- Access cycle for x: state==OWNx and rx_req==1. Each access increments burst count (saturates at MAX_BURST).
- Memory mux: in OWNx, mem_addr/mem_wdata = rx_addr/rx_wdata; mem_we = rx_req & rx_we. In IDLE: mem_addr=0, mem_wdata=0, mem_we=0.
- IDLE: no req → stay. One req → OWN of that side. Both → side ≠ last_owner.
- OWNx, rx_req low: → OWN(other) if other req, else IDLE; no access this cycle, mem_we=0.
- OWNx, rx_req high, count==MAX_BURST-1 before this access (i.e. this access is the MAX_BURST-th) and other req high: → OWN(other) at the edge ending this access.
- OWNx, rx_req high otherwise: stay; if other side idle, burst continues past MAX_BURST indefinitely.
- Entering any OWN state clears count to 0 and sets last_owner to the new owner.
- rx_rvalid(next) = access cycle for x with rx_we==0. rdata is always mem_rdata (memory unit registers out_data on the same edge).
- Reset values: state=IDLE, both gnt=0, both rvalid=0, count=0, last_owner=1 (so r0 wins first tie). mem_* outputs follow IDLE values.
- Reset mid-burst: ownership dropped immediately, pending rvalid discarded; requester must re-request.

## Timing
- req→gnt: 1 cycle from IDLE (req high before edge N, gnt high after edge N).
- First access: the cycle gnt is high and req still high.
- Read latency: rvalid high in the cycle after the read access cycle, for exactly 1 cycle per access; back-to-back reads give continuous rvalid.
- Writes: committed by memory unit during the access cycle (falling edge); no write acknowledge.
- Handover: zero bubble when the other side is requesting; gnt of old owner falls and new gnt rises on the same edge.
- Release with no other requester: one IDLE cycle minimum before next grant.
- Simultaneous req rise from IDLE: one grant only, decided by last_owner.

## Test plan
- Reset then r0_req=1, r0_we=0, r0_addr=0x010 at cycle 0 → r0_gnt=1 after edge 1, mem_addr=0x010, r0_rvalid=1 next cycle with rdata = memory[0x010]; r1_gnt stays 0.
- r0 and r1 both request from IDLE after reset → r0 granted; after r0 drops, r1 granted same edge; next tie from IDLE → r0 granted (last_owner=1).
- r0 holds req for 20 writes, r1 requests at cycle 3 → r0 completes exactly 8 accesses, r1_gnt rises on the edge after r0's 8th, no idle cycle; mem_we never asserted for r1 before r1_gnt.
- r0 holds req for 20 accesses with r1 idle → r0 keeps grant all 20 cycles, count saturates, no spurious handover.
- Owner drops req for one cycle while granted, other idle → mem_we=0 that cycle, state → IDLE, gnt=0 next cycle.
- Assert reset during r1 read burst (read issued previous cycle) → r1_gnt and r1_rvalid 0 immediately, mem_we=0, state IDLE; after reset release with r0_req high, r0 granted in 1 cycle.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory-unit port.
// The arbiter uses the slave view. The requesters and the memory unit
// together use the master view.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);

  // Requester 0 (CPU datapath)
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;

  // Requester 1 (DMA / debug loader)
  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;

  // Shared read data returned to whichever side owns the port
  logic [DATA_W-1:0] rdata;

  // Memory unit side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_rvalid,
    output r1_gnt, r1_rvalid,
    output rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_rvalid,
    input  r1_gnt, r1_rvalid,
    input  rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for the single memory-unit port.
// Ownership is granted through a registered request/grant handshake.
// The owner's address, write data and write enable are muxed onto the
// memory port. A registered read-valid strobe goes back to the owner.
// A bounded burst length forces a handover when the other side is waiting.
module ram_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_lastOwner;
  logic             w_lastOwnerNext;
  logic             r_rvalid0;
  logic             r_rvalid1;

  logic             w_access0;
  logic             w_access1;
  logic             w_burstDone;
  logic             w_enterOwn;

  // A cycle is an access only when the owner is still holding its request.
  assign w_access0 = (r_state == ST_OWN0) && bus.r0_req;
  assign w_access1 = (r_state == ST_OWN1) && bus.r1_req;

  // The current access is the MAX_BURST-th (or later, if the count has already
  // saturated while the other side was idle). This opens the handover window.
  assign w_burstDone = (r_count >= CNT_LAST);

  // Next-owner decision: ties from idle go to the side that did not own last,
  // and a waiting requester takes over after a release or a full burst.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.r0_req && bus.r1_req) begin
          w_stateNext = r_lastOwner ? ST_OWN0 : ST_OWN1;
        end else if (bus.r0_req) begin
          w_stateNext = ST_OWN0;
        end else if (bus.r1_req) begin
          w_stateNext = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!bus.r0_req) begin
          w_stateNext = bus.r1_req ? ST_OWN1 : ST_IDLE;
        end else if (bus.r1_req && w_burstDone) begin
          w_stateNext = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!bus.r1_req) begin
          w_stateNext = bus.r0_req ? ST_OWN0 : ST_IDLE;
        end else if (bus.r0_req && w_burstDone) begin
          w_stateNext = ST_OWN0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Any change of state that lands in an OWN state is a fresh grant.
  assign w_enterOwn = (w_stateNext != r_state) && (w_stateNext != ST_IDLE);

  // The burst counter restarts on every fresh grant. It saturates so that an
  // uncontested owner can keep the port forever without wrapping.
  always_comb begin
    w_countNext     = r_count;
    w_lastOwnerNext = r_lastOwner;
    if (w_enterOwn) begin
      w_countNext     = '0;
      w_lastOwnerNext = (w_stateNext == ST_OWN1);
    end else if ((w_access0 || w_access1) && (r_count != CNT_MAX)) begin
      w_countNext = r_count + 1'b1;
    end
  end

  // Ownership state, burst count and round-robin memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_lastOwner <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_lastOwner <= w_lastOwnerNext;
    end
  end

  // The memory unit registers out_data on the access edge. Read valid
  // therefore follows each read access by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_access0 && !bus.r0_we;
      r_rvalid1 <= w_access1 && !bus.r1_we;
    end
  end

  // Steer the owner's request onto the memory port. The port is parked at
  // zero when idle so no stray write can reach the memory unit.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    case (r_state)
      ST_OWN0: begin
        bus.mem_addr  = bus.r0_addr;
        bus.mem_wdata = bus.r0_wdata;
        bus.mem_we    = bus.r0_req && bus.r0_we;
      end
      ST_OWN1: begin
        bus.mem_addr  = bus.r1_addr;
        bus.mem_wdata = bus.r1_wdata;
        bus.mem_we    = bus.r1_req && bus.r1_we;
      end
      default: begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
      end
    endcase
  end

  assign bus.r0_gnt    = (r_state == ST_OWN0);
  assign bus.r1_gnt    = (r_state == ST_OWN1);
  assign bus.r0_rvalid = r_rvalid0;
  assign bus.r1_rvalid = r_rvalid1;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small memory-unit model.
// Expected read results go into a queue when a read access is set up.
// They are popped and compared when the owner's read-valid strobe appears.
module tb_ram_port_arbiter;

  logic clk;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit          owner;
    logic [15:0] data;
  } expRead_t;

  expRead_t expQ[$];

  bit [15:0] memArr  [0:2047];
  bit        written [0:2047];

  int accesses0;

  ram_port_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  ram_port_arbiter #(
    .ADDR_W   (11),
    .DATA_W   (16),
    .MAX_BURST(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of never-written locations come from a fixed address pattern.
  function automatic logic [15:0] pattern(input logic [10:0] a);
    return 16'h1234 ^ {a, 5'b10101};
  endfunction

  // Memory unit: synchronous write and registered read (old data on collision).
  always @(posedge clk) begin
    if (bus.mem_we) begin
      memArr[bus.mem_addr]  <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= written[bus.mem_addr] ? memArr[bus.mem_addr] : pattern(bus.mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int side, input bit req, input bit we,
                               input logic [10:0] addr, input logic [15:0] wdata);
    if (side == 0) begin
      bus.r0_req   = req;
      bus.r0_we    = we;
      bus.r0_addr  = addr;
      bus.r0_wdata = wdata;
    end else begin
      bus.r1_req   = req;
      bus.r1_we    = we;
      bus.r1_addr  = addr;
      bus.r1_wdata = wdata;
    end
  endtask

  task automatic pushRead(input bit owner, input logic [10:0] addr);
    expRead_t e;
    e.owner = owner;
    e.data  = pattern(addr);
    expQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSample();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    expQ.delete();
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 11'h000, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard consumer: every read-valid strobe must match the oldest expected read.
  always @(negedge clk) begin
    expRead_t e;
    if (!reset && (bus.r0_rvalid || bus.r1_rvalid)) begin
      if (expQ.size() == 0) begin
        checkOutput("rvalid_unexpected", 32'({bus.r1_rvalid, bus.r0_rvalid}), 32'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("rvalid_owner", 32'({bus.r1_rvalid, bus.r0_rvalid}), e.owner ? 32'(2) : 32'(1));
        checkOutput("rdata", 32'(bus.rdata), 32'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 11'h000, 16'h0000);

    // ---------------- reset state ----------------
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_gnt0",   32'(bus.r0_gnt),    32'(0));
    checkOutput("rst_gnt1",   32'(bus.r1_gnt),    32'(0));
    checkOutput("rst_rv0",    32'(bus.r0_rvalid), 32'(0));
    checkOutput("rst_rv1",    32'(bus.r1_rvalid), 32'(0));
    checkOutput("rst_maddr",  32'(bus.mem_addr),  32'(0));
    checkOutput("rst_mwdata", 32'(bus.mem_wdata), 32'(0));
    checkOutput("rst_mwe",    32'(bus.mem_we),    32'(0));
    reset = 1'b0;

    // ---------------- single read by r0 ----------------
    applyStimulus(0, 1'b1, 1'b0, 11'h010, 16'h0000);
    waitSample();
    checkOutput("t1_gnt0_c0", 32'(bus.r0_gnt), 32'(0));
    nextCycle();
    pushRead(0, 11'h010);
    waitSample();
    checkOutput("t1_gnt0_c1",  32'(bus.r0_gnt),   32'(1));
    checkOutput("t1_gnt1_c1",  32'(bus.r1_gnt),   32'(0));
    checkOutput("t1_maddr_c1", 32'(bus.mem_addr), 32'(11'h010));
    checkOutput("t1_mwe_c1",   32'(bus.mem_we),   32'(0));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h010, 16'h0000);
    waitSample();
    checkOutput("t1_rv0_c2",  32'(bus.r0_rvalid), 32'(1));
    checkOutput("t1_gnt1_c2", 32'(bus.r1_gnt),    32'(0));
    nextCycle();
    waitSample();
    checkOutput("t1_gnt0_c3", 32'(bus.r0_gnt),    32'(0));
    checkOutput("t1_rv0_c3",  32'(bus.r0_rvalid), 32'(0));

    // ---------------- ties and zero-bubble handover ----------------
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 11'h020, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 11'h030, 16'h0000);
    nextCycle();
    pushRead(0, 11'h020);
    waitSample();
    checkOutput("t2_tie1_gnt0", 32'(bus.r0_gnt),   32'(1));
    checkOutput("t2_tie1_gnt1", 32'(bus.r1_gnt),   32'(0));
    checkOutput("t2_maddr0",    32'(bus.mem_addr), 32'(11'h020));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h020, 16'h0000);
    waitSample();
    checkOutput("t2_rel_mwe",  32'(bus.mem_we), 32'(0));
    checkOutput("t2_rel_gnt0", 32'(bus.r0_gnt), 32'(1));
    nextCycle();
    pushRead(1, 11'h030);
    waitSample();
    checkOutput("t2_ho_gnt0",  32'(bus.r0_gnt),   32'(0));
    checkOutput("t2_ho_gnt1",  32'(bus.r1_gnt),   32'(1));
    checkOutput("t2_ho_maddr", 32'(bus.mem_addr), 32'(11'h030));
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 11'h030, 16'h0000);
    waitSample();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 11'h021, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 11'h031, 16'h0000);
    waitSample();
    checkOutput("t2_idle_gnt0", 32'(bus.r0_gnt), 32'(0));
    checkOutput("t2_idle_gnt1", 32'(bus.r1_gnt), 32'(0));
    nextCycle();
    pushRead(0, 11'h021);
    waitSample();
    checkOutput("t2_tie2_gnt0", 32'(bus.r0_gnt), 32'(1));
    checkOutput("t2_tie2_gnt1", 32'(bus.r1_gnt), 32'(0));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h021, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 11'h031, 16'h0000);
    waitSample();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 11'h022, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 11'h032, 16'h0000);
    waitSample();
    checkOutput("t2_idle2_gnt", 32'({bus.r1_gnt, bus.r0_gnt}), 32'(0));
    nextCycle();
    pushRead(1, 11'h032);
    waitSample();
    checkOutput("t2_tie3_gnt0", 32'(bus.r0_gnt), 32'(0));
    checkOutput("t2_tie3_gnt1", 32'(bus.r1_gnt), 32'(1));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h022, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 11'h032, 16'h0000);
    waitSample();
    nextCycle();
    waitSample();

    // ---------------- forced handover after MAX_BURST writes ----------------
    doReset();
    accesses0 = 0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) nextCycle();
      applyStimulus(0, 1'b1, 1'b1, 11'(32'h400 + k), 16'(32'hB000 + k));
      if (k >= 3) applyStimulus(1, 1'b1, 1'b1, 11'h500, 16'hC000);
      waitSample();
      if (bus.r0_gnt && bus.r0_req) accesses0++;
      checkOutput("t3_gnt0", 32'(bus.r0_gnt), (k >= 1 && k <= 8) ? 32'(1) : 32'(0));
      checkOutput("t3_gnt1", 32'(bus.r1_gnt), (k == 9) ? 32'(1) : 32'(0));
      checkOutput("t3_mwe",  32'(bus.mem_we), (k >= 1) ? 32'(1) : 32'(0));
      checkOutput("t3_maddr", 32'(bus.mem_addr),
                  (k == 0) ? 32'(0) : (k <= 8) ? 32'h400 + 32'(k) : 32'h500);
      checkOutput("t3_mwdata", 32'(bus.mem_wdata),
                  (k == 0) ? 32'(0) : (k <= 8) ? 32'hB000 + 32'(k) : 32'hC000);
    end
    checkOutput("t3_r0_accesses", 32'(accesses0), 32'(8));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 11'h000, 16'h0000);
    waitSample();
    checkOutput("t3_rel_mwe", 32'(bus.mem_we), 32'(0));
    nextCycle();
    waitSample();
    checkOutput("t3_idle_gnt",  32'({bus.r1_gnt, bus.r0_gnt}), 32'(0));
    checkOutput("t3_mem_0x404", 32'(memArr[11'h404]), 32'hB004);
    checkOutput("t3_mem_0x500", 32'(memArr[11'h500]), 32'hC000);

    // ---------------- uncontested long read burst ----------------
    doReset();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) nextCycle();
      applyStimulus(0, 1'b1, 1'b0, 11'(32'h100 + k), 16'h0000);
      if (k >= 1) pushRead(0, 11'(32'h100 + k));
      waitSample();
      checkOutput("t4_gnt0", 32'(bus.r0_gnt), (k >= 1) ? 32'(1) : 32'(0));
      checkOutput("t4_gnt1", 32'(bus.r1_gnt), 32'(0));
    end
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    waitSample();
    checkOutput("t4_last_rv0", 32'(bus.r0_rvalid), 32'(1));
    nextCycle();
    waitSample();
    checkOutput("t4_end_gnt0", 32'(bus.r0_gnt),    32'(0));
    checkOutput("t4_end_rv0",  32'(bus.r0_rvalid), 32'(0));

    // ---------------- one-cycle request drop, other side idle ----------------
    doReset();
    applyStimulus(0, 1'b1, 1'b1, 11'h600, 16'h1111);
    nextCycle();
    waitSample();
    checkOutput("t5_gnt0_on", 32'(bus.r0_gnt), 32'(1));
    checkOutput("t5_mwe_on",  32'(bus.mem_we), 32'(1));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b1, 11'h600, 16'h1111);
    waitSample();
    checkOutput("t5_drop_mwe",  32'(bus.mem_we), 32'(0));
    checkOutput("t5_drop_gnt0", 32'(bus.r0_gnt), 32'(1));
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 11'h601, 16'h2222);
    waitSample();
    checkOutput("t5_idle_gnt0", 32'(bus.r0_gnt), 32'(0));
    checkOutput("t5_idle_mwe",  32'(bus.mem_we), 32'(0));
    nextCycle();
    waitSample();
    checkOutput("t5_regnt_gnt0",  32'(bus.r0_gnt),   32'(1));
    checkOutput("t5_regnt_maddr", 32'(bus.mem_addr), 32'(11'h601));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    waitSample();
    nextCycle();
    waitSample();

    // ---------------- reset in the middle of an r1 read burst ----------------
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 11'h200, 16'h0000);
    waitSample();
    checkOutput("t6_gnt1_c0", 32'(bus.r1_gnt), 32'(0));
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 11'h201, 16'h0000);
    pushRead(1, 11'h201);
    waitSample();
    checkOutput("t6_gnt1_c1", 32'(bus.r1_gnt), 32'(1));
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 11'h202, 16'h0000);
    pushRead(1, 11'h202);
    waitSample();
    checkOutput("t6_rv1_c2", 32'(bus.r1_rvalid), 32'(1));
    nextCycle();
    reset = 1'b1;
    expQ.delete();
    applyStimulus(1, 1'b0, 1'b0, 11'h000, 16'h0000);
    applyStimulus(0, 1'b1, 1'b0, 11'h050, 16'h0000);
    #1;
    checkOutput("t6_rst_gnt1",  32'(bus.r1_gnt),    32'(0));
    checkOutput("t6_rst_rv1",   32'(bus.r1_rvalid), 32'(0));
    checkOutput("t6_rst_mwe",   32'(bus.mem_we),    32'(0));
    checkOutput("t6_rst_maddr", 32'(bus.mem_addr),  32'(0));
    nextCycle();
    nextCycle();
    reset = 1'b0;
    waitSample();
    checkOutput("t6_post_gnt0_c0", 32'(bus.r0_gnt), 32'(0));
    nextCycle();
    pushRead(0, 11'h050);
    waitSample();
    checkOutput("t6_post_gnt0_c1", 32'(bus.r0_gnt), 32'(1));
    checkOutput("t6_post_gnt1_c1", 32'(bus.r1_gnt), 32'(0));
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 11'h000, 16'h0000);
    waitSample();
    nextCycle();
    waitSample();
    checkOutput("t6_end_gnt", 32'({bus.r1_gnt, bus.r0_gnt}), 32'(0));

    // Every expected read must have been matched by a read-valid strobe.
    checkOutput("sb_drained", 32'(expQ.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
